// File: rtl/reg_file_write_scheduler_pkg.sv
// Shared constants and write-port structs for the register-file write scheduler.
package reg_file_write_scheduler_pkg;

  localparam int REG_FILE_NUM_REGS  = 16;
  localparam int REG_FILE_SEL_WIDTH = $clog2(REG_FILE_NUM_REGS);
  localparam int REG_FILE_DATA_WIDTH = 32;

  // One writeback request as presented by a requester.
  typedef struct packed {
    logic                           valid;
    logic [REG_FILE_SEL_WIDTH-1:0]  sel;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
  } PortIn_RegWriteReq;

  // Register-file write-side fields driven by the scheduler.
  typedef struct packed {
    logic                           write_en;
    logic [REG_FILE_SEL_WIDTH-1:0]  write_sel;
    logic [REG_FILE_DATA_WIDTH-1:0] write_data;
  } PortOut_RegWriteSched;

endpackage

// File: rtl/reg_file_write_scheduler_if.sv
// Writeback handshake (two requesters) plus the register-file write port.
// master = writeback sources / register file side, slave = the scheduler.
interface reg_file_write_scheduler_if
  import reg_file_write_scheduler_pkg::*;
#(
  parameter int SEL_WIDTH  = REG_FILE_SEL_WIDTH,
  parameter int DATA_WIDTH = REG_FILE_DATA_WIDTH
);
  logic                  req0_valid;
  logic [SEL_WIDTH-1:0]  req0_sel;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [SEL_WIDTH-1:0]  req1_sel;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  rf_write_en;
  logic [SEL_WIDTH-1:0]  rf_write_sel;
  logic [DATA_WIDTH-1:0] rf_write_data;

  modport master (
    output req0_valid, req0_sel, req0_data, req1_valid, req1_sel, req1_data,
    input  req0_ready, req1_ready, rf_write_en, rf_write_sel, rf_write_data
  );

  modport slave (
    input  req0_valid, req0_sel, req0_data, req1_valid, req1_sel, req1_data,
    output req0_ready, req1_ready, rf_write_en, rf_write_sel, rf_write_data
  );
endinterface

// File: rtl/reg_file_write_scheduler_arbiter.sv
// Two-way round-robin arbiter with one-hot grant; owns the rr_last state.
// rr_last resets to 1 so req0 wins the first conflict.
module reg_write_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic rr_last_q, rr_last_d;

  // Grant: lone requester wins; on conflict, the one not granted last time.
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11)   grant = rr_last_q ? 2'b01 : 2'b10;
    else                  grant = valid;
    rr_last_d = rr_last_q;
    if (grant[1])         rr_last_d = 1'b1;
    else if (grant[0])    rr_last_d = 1'b0;
  end

  // rr_last register.
  always_ff @(posedge clk) begin
    if (rst) rr_last_q <= 1'b1;
    else     rr_last_q <= rr_last_d;
  end
endmodule

// File: rtl/reg_file_write_scheduler.sv
// Register-file write scheduler: round-robin shares the single write port
// between execute (req0) and load (req1), registers the winning write, and
// keeps a pending-destination scoreboard that drives the decode stall.
// Optional forwarding of the in-flight write: define REG_FILE_WRITE_SCHED_BYPASS_EN.
module reg_file_write_scheduler
  import reg_file_write_scheduler_pkg::*;
#(
  parameter int NUM_REGS   = REG_FILE_NUM_REGS,
  parameter int SEL_WIDTH  = REG_FILE_SEL_WIDTH,
  parameter int DATA_WIDTH = REG_FILE_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_file_write_scheduler_if.slave wb,
  input  logic                  reserve_en,
  input  logic [SEL_WIDTH-1:0]  reserve_sel,
  input  logic                  chk_en_ra,
  input  logic                  chk_en_rb,
  input  logic                  chk_en_rc,
  input  logic [SEL_WIDTH-1:0]  chk_sel_ra,
  input  logic [SEL_WIDTH-1:0]  chk_sel_rb,
  input  logic [SEL_WIDTH-1:0]  chk_sel_rc,
  input  logic                  chk_en_dest,
  input  logic [SEL_WIDTH-1:0]  chk_sel_dest,
`ifdef REG_FILE_WRITE_SCHED_BYPASS_EN
  output logic                  fwd_hit_ra,
  output logic                  fwd_hit_rb,
  output logic                  fwd_hit_rc,
  output logic [DATA_WIDTH-1:0] fwd_data_ra,
  output logic [DATA_WIDTH-1:0] fwd_data_rb,
  output logic [DATA_WIDTH-1:0] fwd_data_rc,
`endif
  output logic                  stall,
  output logic                  err_double_reserve
);
  PortIn_RegWriteReq    req0, req1;
  PortOut_RegWriteSched wr_q, wr_d;
  logic [1:0]           grant;
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic                 err_q, err_d;

  assign req0 = '{valid: wb.req0_valid, sel: wb.req0_sel, data: wb.req0_data};
  assign req1 = '{valid: wb.req1_valid, sel: wb.req1_sel, data: wb.req1_data};

  reg_write_rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid ({req1.valid, req0.valid}),
    .grant (grant)
  );

  assign wb.req0_ready    = grant[0];
  assign wb.req1_ready    = grant[1];
  assign wb.rf_write_en   = wr_q.write_en;
  assign wb.rf_write_sel  = wr_q.write_sel;
  assign wb.rf_write_data = wr_q.write_data;
  assign err_double_reserve = err_q;

  // Next write-port value: the granted request, with r0 writes swallowed.
  // Select/data hold their last value when nothing is written.
  always_comb begin
    wr_d          = wr_q;
    wr_d.write_en = 1'b0;
    if (grant[0]) begin
      wr_d.write_en   = (req0.sel != '0);
      wr_d.write_sel  = req0.sel;
      wr_d.write_data = req0.data;
    end else if (grant[1]) begin
      wr_d.write_en   = (req1.sel != '0);
      wr_d.write_sel  = req1.sel;
      wr_d.write_data = req1.data;
    end
  end

  // Scoreboard: landing write clears, reserve sets; set applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (wr_q.write_en) busy_d[wr_q.write_sel] = 1'b0;
    if (reserve_en && reserve_sel != '0) begin
      busy_d[reserve_sel] = 1'b1;
      if (busy_q[reserve_sel]) err_d = 1'b1;
    end
  end

  // Write-port, scoreboard and sticky-error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

`ifdef REG_FILE_WRITE_SCHED_BYPASS_EN
  assign fwd_hit_ra  = chk_en_ra && wr_q.write_en && (chk_sel_ra == wr_q.write_sel) && (chk_sel_ra != '0);
  assign fwd_hit_rb  = chk_en_rb && wr_q.write_en && (chk_sel_rb == wr_q.write_sel) && (chk_sel_rb != '0);
  assign fwd_hit_rc  = chk_en_rc && wr_q.write_en && (chk_sel_rc == wr_q.write_sel) && (chk_sel_rc != '0);
  assign fwd_data_ra = wr_q.write_data;
  assign fwd_data_rb = wr_q.write_data;
  assign fwd_data_rc = wr_q.write_data;

  // Stall: sources covered by the in-flight write are forwarded; dest never is.
  always_comb begin
    stall = (chk_en_ra && busy_q[chk_sel_ra] && !fwd_hit_ra) ||
            (chk_en_rb && busy_q[chk_sel_rb] && !fwd_hit_rb) ||
            (chk_en_rc && busy_q[chk_sel_rc] && !fwd_hit_rc) ||
            (chk_en_dest && busy_q[chk_sel_dest]);
  end
`else
  // Stall: any enabled check that names a pending register.
  always_comb begin
    stall = (chk_en_ra   && busy_q[chk_sel_ra])   ||
            (chk_en_rb   && busy_q[chk_sel_rb])   ||
            (chk_en_rc   && busy_q[chk_sel_rc])   ||
            (chk_en_dest && busy_q[chk_sel_dest]);
  end
`endif
endmodule

// File: tb/tb_reg_file_write_scheduler.sv
// Directed bench for reg_file_write_scheduler (both build variants).
module tb_reg_file_write_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        reserve_en;
  logic [3:0]  reserve_sel;
  logic        chk_en_ra, chk_en_rb, chk_en_rc, chk_en_dest;
  logic [3:0]  chk_sel_ra, chk_sel_rb, chk_sel_rc, chk_sel_dest;
  logic        stall, err_double_reserve;
`ifdef REG_FILE_WRITE_SCHED_BYPASS_EN
  logic        fwd_hit_ra, fwd_hit_rb, fwd_hit_rc;
  logic [31:0] fwd_data_ra, fwd_data_rb, fwd_data_rc;
`endif
  int total = 0;
  int bad   = 0;

  reg_file_write_scheduler_if wb ();

  reg_file_write_scheduler dut (
    .clk (clk), .rst (rst), .wb (wb.slave),
    .reserve_en (reserve_en), .reserve_sel (reserve_sel),
    .chk_en_ra (chk_en_ra), .chk_en_rb (chk_en_rb), .chk_en_rc (chk_en_rc),
    .chk_sel_ra (chk_sel_ra), .chk_sel_rb (chk_sel_rb), .chk_sel_rc (chk_sel_rc),
    .chk_en_dest (chk_en_dest), .chk_sel_dest (chk_sel_dest),
`ifdef REG_FILE_WRITE_SCHED_BYPASS_EN
    .fwd_hit_ra (fwd_hit_ra), .fwd_hit_rb (fwd_hit_rb), .fwd_hit_rc (fwd_hit_rc),
    .fwd_data_ra (fwd_data_ra), .fwd_data_rb (fwd_data_rb), .fwd_data_rc (fwd_data_rc),
`endif
    .stall (stall), .err_double_reserve (err_double_reserve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    reserve_en = 0; reserve_sel = 0;
    chk_en_ra = 0; chk_en_rb = 0; chk_en_rc = 0; chk_en_dest = 0;
    chk_sel_ra = 0; chk_sel_rb = 0; chk_sel_rc = 0; chk_sel_dest = 0;
    wb.req0_valid = 0; wb.req0_sel = 0; wb.req0_data = 0;
    wb.req1_valid = 0; wb.req1_sel = 0; wb.req1_data = 0;
    tick(); tick();
    chk("rst_wen",  {31'd0, wb.rf_write_en}, 0);
    chk("rst_wsel", {28'd0, wb.rf_write_sel}, 0);
    chk("rst_wdat", wb.rf_write_data, 0);
    chk("rst_err",  {31'd0, err_double_reserve}, 0);
    chk_en_ra = 1; chk_sel_ra = 4'd5; #1;
    chk("rst_stall", {31'd0, stall}, 0);
    chk_en_ra = 0;
    rst = 1'b0;

    // req0 alone writes r3
    wb.req0_valid = 1; wb.req0_sel = 4'd3; wb.req0_data = 32'hDEADBEEF; #1;
    chk("t1_rdy0", {31'd0, wb.req0_ready}, 1);
    chk("t1_rdy1", {31'd0, wb.req1_ready}, 0);
    tick();
    wb.req0_valid = 0;
    chk("t1_wen",  {31'd0, wb.rf_write_en}, 1);
    chk("t1_wsel", {28'd0, wb.rf_write_sel}, 3);
    chk("t1_wdat", wb.rf_write_data, 32'hDEADBEEF);
    tick();
    chk("t1_wen_off", {31'd0, wb.rf_write_en}, 0);

    // req1 alone writes r4 (leaves rr_last = 1)
    wb.req1_valid = 1; wb.req1_sel = 4'd4; wb.req1_data = 32'h44; #1;
    chk("t1b_rdy1", {31'd0, wb.req1_ready}, 1);
    tick();
    wb.req1_valid = 0;
    chk("t1b_wsel", {28'd0, wb.rf_write_sel}, 4);
    chk("t1b_wdat", wb.rf_write_data, 32'h44);

    // both valid for four grants: req0, req1, req0, req1
    wb.req0_valid = 1; wb.req0_sel = 4'd1; wb.req0_data = 32'h11;
    wb.req1_valid = 1; wb.req1_sel = 4'd2; wb.req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_rdy0", {31'd0, wb.req0_ready}, (i % 2 == 0) ? 1 : 0);
      chk("t2_rdy1", {31'd0, wb.req1_ready}, (i % 2 == 0) ? 0 : 1);
      tick();
      chk("t2_wen",  {31'd0, wb.rf_write_en}, 1);
      chk("t2_wsel", {28'd0, wb.rf_write_sel}, (i % 2 == 0) ? 1 : 2);
      chk("t2_wdat", wb.rf_write_data, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    wb.req0_valid = 0; wb.req1_valid = 0;
    tick();
    chk("t2_idle", {31'd0, wb.rf_write_en}, 0);

    // reserve r5, read r5 stalls until the write lands
    reserve_en = 1; reserve_sel = 4'd5;
    tick();
    reserve_en = 0;
    chk_en_ra = 1; chk_sel_ra = 4'd5; #1;
    chk("t3_stall_a", {31'd0, stall}, 1);
    tick();
    chk("t3_stall_b", {31'd0, stall}, 1);
    wb.req0_valid = 1; wb.req0_sel = 4'd5; wb.req0_data = 32'h55; #1;
    chk("t3_rdy0", {31'd0, wb.req0_ready}, 1);
    tick();
    wb.req0_valid = 0;
    chk("t3_wen", {31'd0, wb.rf_write_en}, 1);
`ifdef REG_FILE_WRITE_SCHED_BYPASS_EN
    chk("t3_stall_fwd", {31'd0, stall}, 0);
    chk("t3_fwd_hit",   {31'd0, fwd_hit_ra}, 1);
    chk("t3_fwd_data",  fwd_data_ra, 32'h55);
`else
    chk("t3_stall_inflight", {31'd0, stall}, 1);
`endif
    tick();
    chk("t3_stall_clr", {31'd0, stall}, 0);
    chk_en_ra = 0;

    // reserve r7 on the edge its write lands: set wins
    wb.req1_valid = 1; wb.req1_sel = 4'd7; wb.req1_data = 32'h77;
    tick();
    wb.req1_valid = 0;
    chk("t4_wsel", {28'd0, wb.rf_write_sel}, 7);
    reserve_en = 1; reserve_sel = 4'd7;
    tick();
    reserve_en = 0;
    chk_en_rb = 1; chk_sel_rb = 4'd7; #1;
    chk("t4_stall_a", {31'd0, stall}, 1);
    chk("t4_err_a",   {31'd0, err_double_reserve}, 0);
    tick();
    chk("t4_stall_b", {31'd0, stall}, 1);
    chk_en_rb = 0; chk_en_dest = 1; chk_sel_dest = 4'd7; #1;
    chk("t4_waw", {31'd0, stall}, 1);
    chk_en_dest = 0;
    reserve_en = 1; reserve_sel = 4'd7;
    tick();
    reserve_en = 0;
    chk("t4_err_b", {31'd0, err_double_reserve}, 1);

    // r0: handshake completes, no write, never busy
    wb.req0_valid = 1; wb.req0_sel = 4'd0; wb.req0_data = 32'h1234;
    reserve_en = 1; reserve_sel = 4'd0;
    chk_en_rc = 1; chk_sel_rc = 4'd0; #1;
    chk("t5_rdy0",  {31'd0, wb.req0_ready}, 1);
    chk("t5_stall", {31'd0, stall}, 0);
    tick();
    wb.req0_valid = 0; reserve_en = 0;
    chk("t5_wen",    {31'd0, wb.rf_write_en}, 0);
    chk("t5_stall2", {31'd0, stall}, 0);
    tick();
    chk("t5_stall3", {31'd0, stall}, 0);
    chk_en_rc = 0;

    // reset with r9 in flight (r7 still pending)
    wb.req1_valid = 1; wb.req1_sel = 4'd9; wb.req1_data = 32'h99;
    reserve_en = 1; reserve_sel = 4'd9;
    tick();
    wb.req1_valid = 0; reserve_en = 0;
    chk("t6_wen_pre", {31'd0, wb.rf_write_en}, 1);
    chk("t6_wsel",    {28'd0, wb.rf_write_sel}, 9);
    rst = 1'b1;
    tick();
    chk_en_ra = 1; chk_sel_ra = 4'd9; chk_en_rb = 1; chk_sel_rb = 4'd7; #1;
    chk("t6_wen",   {31'd0, wb.rf_write_en}, 0);
    chk("t6_stall", {31'd0, stall}, 0);
    chk("t6_err",   {31'd0, err_double_reserve}, 0);
    rst = 1'b0;
    chk_en_ra = 0; chk_en_rb = 0;
    wb.req0_valid = 1; wb.req0_sel = 4'd1; wb.req1_valid = 1; wb.req1_sel = 4'd2; #1;
    chk("t6_rr_rdy0", {31'd0, wb.req0_ready}, 1);
    chk("t6_rr_rdy1", {31'd0, wb.req1_ready}, 0);
    wb.req0_valid = 0; wb.req1_valid = 0;
    tick();
    chk("t6_wen_post", {31'd0, wb.rf_write_en}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_write_scheduler.md
Name: reg_file_write_scheduler

Overview:
- Owns the single write port of the 16x32 register file and shares it between two writeback requesters: req0 (execute/ALU) and req1 (load unit).
- Arbitrates round-robin and registers the winning write onto the register-file write port.
- Keeps a scoreboard of pending destination registers so decode stalls reads of values not yet written.
- Sits between the writeback sources, decode, and the register file. Register-file reads are synchronous and unbypassed; writes to r0 are discarded.

Parameters:
- NUM_REGS, 16, number of architectural registers; r0 reads as zero.
- SEL_WIDTH, 4, register-select width, equal to clog2(NUM_REGS).
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reserve_en  in  1  decode issues an instruction that writes reserve_sel
- reserve_sel  in  SEL_WIDTH  destination register to mark pending
- chk_en_ra / chk_en_rb / chk_en_rc  in  1 each  source operand used
- chk_sel_ra / chk_sel_rb / chk_sel_rc  in  SEL_WIDTH each  source selects
- chk_en_dest  in  1  WAW check enable
- chk_sel_dest  in  SEL_WIDTH  destination to check
- stall  out  1  combinational: some enabled check hits a busy register
- req0_valid, req1_valid  in  1  write request
- req0_sel, req1_sel  in  SEL_WIDTH  write target
- req0_data, req1_data  in  DATA_WIDTH  write data
- req0_ready, req1_ready  out  1  grant, combinational
- rf_write_en  out  1  register-file write enable
- rf_write_sel  out  SEL_WIDTH  register-file write select
- rf_write_data  out  DATA_WIDTH  register-file write data
- err_double_reserve  out  1  sticky: a reserve hit an already-busy register

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port rst.
- Reset values: busy[] = 0, rf_write_en = 0, rf_write_sel = 0, rf_write_data = 0, err_double_reserve = 0, rr_last = 1 (req0 wins the first conflict).
- Reset mid-operation: a write registered but not yet landed is dropped (rf_write_en = 0 the cycle after reset). All pending marks are cleared.
- Handshake: a requester holds valid, sel and data stable until ready = 1. Transfer happens on the edge where valid && ready.
- Arbitration, single valid: that requester is granted.
- Arbitration, both valid: grant the requester other than rr_last.
- rr_last update: set to the granted index on any grant; unchanged when idle.
- At most one ready per cycle.
- Write latency: a grant at edge N drives rf_write_en/sel/data during cycle N+1. The register-file array updates at edge N+1.
- r0 writes: a granted write to sel 0 completes the handshake, but rf_write_en stays 0.
- Scoreboard set: on an edge with reserve_en && reserve_sel != 0, busy[reserve_sel] <= 1. If the bit was already 1, err_double_reserve <= 1.
- Scoreboard clear: on an edge with rf_write_en = 1, busy[rf_write_sel] <= 0. A write to a non-busy register is legal and leaves the bit 0.
- Same-edge set and clear of one register: set wins.
- Stall: stall = OR over enabled checks of busy[sel]. r0 is never busy.
- Stall timing: a stalled read unblocks in the cycle after the write lands (edge N+1), so the synchronous read issued then samples the new value.
- No internal queue: when a requester is not granted, backpressure holds it.

Optional Feature:
- Macro: REG_FILE_WRITE_SCHED_BYPASS_EN.
- With the macro defined:
  - Add outputs fwd_hit_ra/rb/rc (1 bit each) and fwd_data_ra/rb/rc (DATA_WIDTH each).
  - fwd_hit_x = chk_en_x && rf_write_en && rf_write_sel == chk_sel_x (nonzero). fwd_data_x = rf_write_data.
  - A source check that hits the in-flight write does not contribute to stall.
  - The WAW dest check is never bypassed.
- Without the macro: the ports are absent, and stall holds until busy clears.

Decomposition:
- PkgRegisterFile gains REG_FILE_NUM_REGS, REG_FILE_SEL_WIDTH and REG_FILE_DATA_WIDTH.
- PkgRegisterFile also gains packed structs PortIn_RegWriteReq {valid, sel, data} and PortOut_RegWriteSched {write_en, write_sel, write_data}. The latter matches the register file's write-side fields.
- One sub-module: reg_write_rr_arbiter. It takes two valids and returns one-hot grant, and owns the rr_last state.

Test Plan:
- Reset, then req0 alone writes r3 = 0xDEADBEEF -> req0_ready = 1 at cycle 1; rf_write_en = 1, sel = 3, data = 0xDEADBEEF at cycle 2; rf_write_en = 0 after.
- Both valid for 4 cycles with req0 → r1 and req1 → r2 -> grants alternate req0, req1, req0, req1; rf_write_sel sequence is 1, 2, 1, 2.
- Reserve r5, then check ra = r5 -> stall = 1 until the r5 write lands, 0 the following cycle. With BYPASS_EN: stall = 0 and fwd_data_ra equals the data in the rf_write_en cycle.
- Reserve r7 on the same edge that rf_write_en clears r7 -> busy[7] stays 1 and stall persists. A second reserve of r7 sets err_double_reserve = 1.
- Write to r0 = 0x1234 and reserve r0 -> handshake completes, rf_write_en stays 0, stall never asserts for r0.
- rst asserted with a grant in flight (r9) -> next cycle rf_write_en = 0, all busy bits clear, stall = 0.
